// File: rtl/lif_sched_if.sv
// Step-request and spike-event channels between the input stage, the LIF
// scheduler and the spike router.
interface lif_sched_if #(
   parameter int NUM_NEURONS = 16,
   parameter int MEM_W       = 16,
   parameter int IDX_W       = $clog2(NUM_NEURONS)
) ();
   logic                   step_valid;
   logic                   step_ready;
   logic [NUM_NEURONS-1:0] spike_in;
   logic [MEM_W-1:0]       threshold;
   logic [3:0]             leak_shift;
   logic                   evt_valid;
   logic [IDX_W-1:0]       evt_idx;
   logic                   evt_ready;

   modport master (
      output step_valid, spike_in, threshold, leak_shift, evt_ready,
      input  step_ready, evt_valid, evt_idx
   );

   modport slave (
      input  step_valid, spike_in, threshold, leak_shift, evt_ready,
      output step_ready, evt_valid, evt_idx
   );
endinterface

// File: rtl/lif_layer_scheduler.sv
// Time-multiplexed LIF layer: one shared integrate/leak/fire datapath walks
// NUM_NEURONS stored membrane potentials per timestep and emits spike events.
//
// state  | meaning
// IDLE   | waiting for a timestep; clear_mem honoured here
// UPDATE | evaluate neuron idx (fire or integrate/leak)
// EMIT   | holding spike event for neuron idx until the router takes it
// DONE   | one-cycle step_done pulse
module lif_layer_scheduler #(
   parameter int NUM_NEURONS = 16,
   parameter int MEM_W       = 16,
   parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
   input  logic             clk,
   input  logic             rst,
   lif_sched_if.slave       bus,
   input  logic             clear_mem,
   output logic             step_done,
   output logic             busy,
   input  logic [IDX_W-1:0] dbg_idx,
   output logic [MEM_W-1:0] dbg_potential
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_UPDATE = 2'd1;
   localparam logic [1:0] S_EMIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   logic [1:0]             state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [MEM_W-1:0]       pot_q [NUM_NEURONS];
   logic [MEM_W-1:0]       pot_d [NUM_NEURONS];
   logic [NUM_NEURONS-1:0] spike_q, spike_d;
   logic [MEM_W-1:0]       thr_q, thr_d;
   logic [3:0]             shift_q, shift_d;
   logic                   evt_valid_q, evt_valid_d;
   logic [IDX_W-1:0]       evt_idx_q, evt_idx_d;

   logic [MEM_W-1:0]       p_cur;
   logic [MEM_W-1:0]       integ;
   logic [MEM_W-1:0]       leak;
   logic [MEM_W:0]         sum;
   logic [MEM_W-1:0]       p_upd;
   logic                   fire;
   logic                   last;

   // leak <= p, so the extra MSB of sum can only mean overflow, never underflow.
   // A logical shift by >= MEM_W yields zero leak on its own.
   always_comb begin
      p_cur = pot_q[idx_q];
      integ = spike_q[idx_q] ? (thr_q >> 2) : '0;
      leak  = p_cur >> shift_q;
      sum   = {1'b0, p_cur} + {1'b0, integ} - {1'b0, leak};
      p_upd = sum[MEM_W] ? '1 : sum[MEM_W-1:0];
      fire  = (p_cur >= thr_q);
      last  = (idx_q == LAST_IDX);
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pot_d       = pot_q;
      spike_d     = spike_q;
      thr_d       = thr_q;
      shift_d     = shift_q;
      evt_valid_d = evt_valid_q;
      evt_idx_d   = evt_idx_q;

      case (state_q)
         S_IDLE: begin
            if (clear_mem) begin
               for (int i = 0; i < NUM_NEURONS; i++) begin
                  pot_d[i] = '0;
               end
            end else if (bus.step_valid) begin
               spike_d = bus.spike_in;
               thr_d   = bus.threshold;
               shift_d = bus.leak_shift;
               idx_d   = '0;
               state_d = S_UPDATE;
            end
         end

         S_UPDATE: begin
            if (fire) begin
               pot_d[idx_q] = '0;
               evt_idx_d    = idx_q;
               evt_valid_d  = 1'b1;
               state_d      = S_EMIT;
            end else begin
               pot_d[idx_q] = p_upd;
               if (last) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         S_EMIT: begin
            if (bus.evt_ready) begin
               evt_valid_d = 1'b0;
               if (last) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_UPDATE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         spike_q     <= '0;
         thr_q       <= '0;
         shift_q     <= '0;
         evt_valid_q <= 1'b0;
         evt_idx_q   <= '0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            pot_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         spike_q     <= spike_d;
         thr_q       <= thr_d;
         shift_q     <= shift_d;
         evt_valid_q <= evt_valid_d;
         evt_idx_q   <= evt_idx_d;
         pot_q       <= pot_d;
      end
   end

   assign bus.step_ready = (state_q == S_IDLE) && !clear_mem;
   assign bus.evt_valid  = evt_valid_q;
   assign bus.evt_idx    = evt_idx_q;
   assign step_done      = (state_q == S_DONE);
   assign busy           = (state_q != S_IDLE);
   assign dbg_potential  = (int'(dbg_idx) < NUM_NEURONS) ? pot_q[dbg_idx] : '0;

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Bench for lif_layer_scheduler: per-step behavioural model of the whole
// layer, event scoreboard, timing checks and randomized timesteps.
module tb_lif_layer_scheduler;
   localparam int N  = 16;
   localparam int MW = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear_mem = 1'b0;
   logic          step_done;
   logic          busy;
   logic [IW-1:0] dbg_idx = '0;
   logic [MW-1:0] dbg_potential;

   lif_sched_if #(.NUM_NEURONS(N), .MEM_W(MW)) bus ();

   lif_layer_scheduler #(.NUM_NEURONS(N), .MEM_W(MW)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .clear_mem     (clear_mem),
      .step_done     (step_done),
      .busy          (busy),
      .dbg_idx       (dbg_idx),
      .dbg_potential (dbg_potential)
   );

   always #50 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int m_pot [N];
   int exp_q [$];
   int rdy_mode = 1;
   int done_cnt = 0;
   int ev_cnt = 0;
   int exp_done = -1;
   int last_acc = 0;
   int last_done = 0;
   bit prev_v = 0;
   bit prev_r = 0;
   int prev_i = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       bus.evt_ready = 1'b0;
         1:       bus.evt_ready = 1'b1;
         default: bus.evt_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Compare process: event order/stability and step_done timing.
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 0;
      end else begin
         if (prev_v && !prev_r) begin
            check("evt_hold_valid", int'(bus.evt_valid), 1);
            check("evt_hold_idx", int'(bus.evt_idx), prev_i);
         end
         if (bus.evt_valid && bus.evt_ready) begin
            ev_cnt++;
            if (exp_q.size() == 0) check("evt_unexpected_idx", int'(bus.evt_idx), 99);
            else check("evt_idx", int'(bus.evt_idx), exp_q.pop_front());
         end
         if (step_done) begin
            done_cnt++;
            last_done = cyc;
            check("busy_in_done", int'(busy), 1);
            if (exp_done >= 0) check("done_cycle", cyc, exp_done);
         end
         prev_v = bus.evt_valid;
         prev_r = bus.evt_ready;
         prev_i = int'(bus.evt_idx);
      end
   end

   // Whole-timestep model straight from the integrate/leak/fire rule.
   task automatic model_step(input logic [N-1:0] spk, input int thr, input int sh, output int fires);
      fires = 0;
      for (int i = 0; i < N; i++) begin
         int p;
         p = m_pot[i];
         if (p >= thr) begin
            exp_q.push_back(i);
            m_pot[i] = 0;
            fires++;
         end else begin
            int inc;
            int lk;
            int v;
            inc = spk[i] ? thr / 4 : 0;
            lk  = (sh >= MW) ? 0 : p / (1 << sh);
            v   = p + inc - lk;
            m_pot[i] = (v > 65535) ? 65535 : v;
         end
      end
   endtask

   task automatic check_all_pots();
      for (int i = 0; i < N; i++) begin
         dbg_idx = IW'(i);
         #1;
         check($sformatf("pot[%0d]", i), int'(dbg_potential), m_pot[i]);
      end
   endtask

   task automatic wait_done(input int start_cnt);
      int n;
      n = 0;
      while (done_cnt == start_cnt && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("done_count", done_cnt, start_cnt + 1);
      @(negedge clk);
      #1;
      check("idle_busy", int'(busy), 0);
      check("idle_ready", int'(bus.step_ready), 1);
      check("evt_drained", exp_q.size(), 0);
   endtask

   task automatic wait_evt();
      int n;
      n = 0;
      while (!bus.evt_valid && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("evt_wait", int'(bus.evt_valid), 1);
   endtask

   // Called with step_valid high and step_ready high just before the accept edge.
   task automatic accept_step(input logic [N-1:0] spk, input int thr, input int sh,
                              input bit timed, input bit wait_it);
      int fires;
      int dc;
      dc = done_cnt;
      last_acc = cyc;
      model_step(spk, thr, sh, fires);
      exp_done = timed ? cyc + N + 1 + fires : -1;
      @(posedge clk);
      #1;
      bus.step_valid = 1'b0;
      bus.spike_in   = N'($urandom);
      bus.threshold  = 16'($urandom);
      bus.leak_shift = 4'($urandom);
      clear_mem      = 1'($urandom_range(0, 1));
      check("busy_after_accept", int'(busy), 1);
      @(negedge clk);
      clear_mem = 1'b0;
      if (wait_it) begin
         wait_done(dc);
         check_all_pots();
      end
   endtask

   task automatic run_step(input logic [N-1:0] spk, input int thr, input int sh,
                           input bit timed, input bit wait_it);
      int n;
      n = 0;
      @(negedge clk);
      bus.spike_in   = spk;
      bus.threshold  = thr[MW-1:0];
      bus.leak_shift = sh[3:0];
      bus.step_valid = 1'b1;
      #1;
      while (!bus.step_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!bus.step_ready) begin
         check("accept_timeout", int'(bus.step_ready), 1);
         bus.step_valid = 1'b0;
      end else begin
         accept_step(spk, thr, sh, timed, wait_it);
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear_mem = 1'b1;
      #1;
      check("clear_ready_low", int'(bus.step_ready), 0);
      @(negedge clk);
      clear_mem = 1'b0;
      for (int i = 0; i < N; i++) m_pot[i] = 0;
   endtask

   int sat_exp [6] = '{16'h3FFF, 16'h7FFE, 16'hBFFD, 16'hFFFB, 16'hFFFF, 0};

   initial begin
      int dc;
      int base;
      bus.step_valid = 1'b0;
      bus.spike_in   = '0;
      bus.threshold  = '0;
      bus.leak_shift = '0;
      for (int i = 0; i < N; i++) m_pot[i] = 0;

      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(step_done), 0);
      check("rst_evt_valid", int'(bus.evt_valid), 0);
      check("rst_evt_idx", int'(bus.evt_idx), 0);
      rst = 1'b0;
      check_all_pots();

      // Quiet step: no events, done N+1 cycles after accept.
      run_step('0, 100, 0, 1, 1);
      check("t1_latency", last_done - last_acc, 17);
      check("t1_events", ev_cnt, 0);

      // Single integrating neuron crossing threshold.
      for (int s = 1; s <= 5; s++) begin
         run_step(16'h0008, 100, 15, 1, 1);
         dbg_idx = 4'd3;
         #1;
         check($sformatf("t2_pot3_step%0d", s), int'(dbg_potential), (s < 5) ? 25 * s : 0);
      end
      check("t2_events", ev_cnt, 1);

      // Threshold zero with router stalled.
      do_clear();
      rdy_mode = 0;
      base = ev_cnt;
      dc = done_cnt;
      run_step('0, 0, 0, 0, 0);
      wait_evt();
      repeat (10) begin
         @(negedge clk);
         #1;
         check("t3_stall_valid", int'(bus.evt_valid), 1);
         check("t3_stall_idx", int'(bus.evt_idx), 0);
      end
      rdy_mode = 1;
      wait_done(dc);
      check("t3_events", ev_cnt - base, 16);
      check_all_pots();

      // Saturation at all-ones, then fire.
      do_clear();
      for (int s = 0; s < 6; s++) begin
         run_step('1, 16'hFFFF, 15, 1, 1);
         dbg_idx = 4'd0;
         #1;
         check($sformatf("t4_sat_step%0d", s + 1), int'(dbg_potential), sat_exp[s]);
      end

      // clear_mem wins over a simultaneous step request.
      run_step('1, 1000, 15, 1, 1);
      @(negedge clk);
      clear_mem      = 1'b1;
      bus.step_valid = 1'b1;
      bus.spike_in   = '1;
      bus.threshold  = 16'd1000;
      bus.leak_shift = 4'd2;
      #1;
      check("t5_ready_low", int'(bus.step_ready), 0);
      @(negedge clk);
      #1;
      check("t5_not_accepted", int'(busy), 0);
      for (int i = 0; i < N; i++) m_pot[i] = 0;
      check_all_pots();
      clear_mem = 1'b0;
      #1;
      check("t5_ready_high", int'(bus.step_ready), 1);
      accept_step('1, 1000, 2, 1, 1);

      // Reset in the middle of EMIT.
      do_clear();
      run_step('1, 400, 3, 1, 1);
      rdy_mode = 0;
      dc = done_cnt;
      run_step('0, 0, 0, 0, 0);
      wait_evt();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t6_evt_valid", int'(bus.evt_valid), 0);
      check("t6_busy", int'(busy), 0);
      check("t6_done", int'(step_done), 0);
      exp_q.delete();
      for (int i = 0; i < N; i++) m_pot[i] = 0;
      check_all_pots();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("t6_no_done", done_cnt, dc);
      rdy_mode = 1;
      run_step(16'h00FF, 40, 1, 1, 1);
      run_step(16'h00FF, 40, 1, 1, 1);

      // Randomized timesteps with random router backpressure.
      rdy_mode = 2;
      for (int k = 0; k < 40; k++) begin
         int thr;
         if ($urandom_range(0, 7) == 0) do_clear();
         thr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60000, 65535))
                                           : int'($urandom_range(0, 3000));
         run_step(N'($urandom), thr, int'($urandom_range(0, 15)), 0, 1);
      end
      rdy_mode = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #(100 * 40000);
      $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end
endmodule
